seg_scan_ctrl: RTL and testbench

- Multiplexed-display scan controller that sits directly upstream of the BCD-to-7-segment decoder.
- Buffers a multi-digit BCD value and time-multiplexes one digit at a time onto the decoder's 4-bit input.
- Drives one-hot digit enables in step with the selected digit, plus a blank qualifier that forces segments off downstream.
- Performs leading-zero blanking and frame-synchronous update so the display never tears mid-frame.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_scan_ctrl_if.sv | 35 +++
 rtl/seg_tick_gen.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 118 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared BCD/7-segment constants and a digit-extraction helper,
//               used by the scan controller and the downstream decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

   localparam int BCD_W      = 4;
   localparam int BCD_MAX    = 9;
   localparam int MAX_DIGITS = 8;
   localparam int PACK_W     = BCD_W * MAX_DIGITS;

   // Return BCD digit idx (0 = least significant) of a packed digit vector.
   function automatic logic [BCD_W-1:0] get_digit(input logic [PACK_W-1:0] vec,
                                                  input int idx);
      return vec[idx*BCD_W +: BCD_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl_if
// Description : Load/display bundle between a digit source (master) and the
//               scan controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_ctrl_if
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);

   logic                          load;
   logic [BCD_W*NUM_DIGITS-1:0]   digits_in;
   logic                          blank_lz;
   logic [BCD_W-1:0]              bcd_out;
   logic [NUM_DIGITS-1:0]         digit_en;
   logic                          blank;
   logic                          err;
   logic                          frame_start;
   logic                          pending;

   modport master (
      output load, digits_in, blank_lz,
      input  bcd_out, digit_en, blank, err, frame_start, pending
   );

   modport slave (
      input  load, digits_in, blank_lz,
      output bcd_out, digit_en, blank, err, frame_start, pending
   );

endinterface
`default_nettype wire

// File: rtl/seg_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : seg_tick_gen
// Description : Free-running prescaler; tick is high for the last cycle of
//               every REFRESH_DIV-cycle period.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_tick_gen #(
   parameter int REFRESH_DIV = 50000
) (
   input  wire logic clk,
   input  wire logic rst,
   output logic      tick
);

   localparam int                CNT_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(REFRESH_DIV - 1);

   logic [CNT_W-1:0] r_count;

   // Count 0..REFRESH_DIV-1 and wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (r_count == C_LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed-display scan controller. Buffers a packed BCD
//               value, scans one digit per refresh slot with one-hot enables,
//               leading-zero blanking and frame-synchronous commit of loads.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  wire logic       clk,
   input  wire logic       rst,
   seg_scan_ctrl_if.slave  bus
);

   localparam int                IDX_W      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
   localparam int                DISP_W     = BCD_W * NUM_DIGITS;
   localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic                  w_tick;
   logic                  w_frame_edge;
   logic [IDX_W-1:0]      w_next_index;
   logic [DISP_W-1:0]     w_next_display;
   logic [BCD_W-1:0]      w_next_digit;
   logic                  w_upper_nonzero;
   logic                  w_next_err;
   logic                  w_next_blank;

   logic [IDX_W-1:0]      r_index;
   logic [DISP_W-1:0]     r_shadow;
   logic [DISP_W-1:0]     r_display;
   logic                  r_pending;
   logic [BCD_W-1:0]      r_bcd_out;
   logic [NUM_DIGITS-1:0] r_digit_en;
   logic                  r_blank;
   logic                  r_err;
   logic                  r_frame_start;

   seg_tick_gen #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Next slot index, post-commit display contents and the slot's outputs.
   always_comb begin
      w_frame_edge    = w_tick && (r_index == C_LAST_IDX);
      w_next_index    = (r_index == C_LAST_IDX) ? '0 : r_index + 1'b1;
      w_next_display  = r_display;
      if (w_frame_edge) begin
         // A load landing on the boundary goes straight to the display.
         if (bus.load) begin
            w_next_display = bus.digits_in;
         end else if (r_pending) begin
            w_next_display = r_shadow;
         end
      end
      w_next_digit    = get_digit(PACK_W'(w_next_display), int'(w_next_index));
      w_upper_nonzero = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((i >= int'(w_next_index)) &&
             (get_digit(PACK_W'(w_next_display), i) != '0)) begin
            w_upper_nonzero = 1'b1;
         end
      end
      w_next_err   = (w_next_digit > BCD_W'(BCD_MAX));
      // Digit 0 is exempt so an all-zero value still shows one "0".
      w_next_blank = w_next_err ||
                     (bus.blank_lz && (w_next_index != '0) && !w_upper_nonzero);
   end

   // Slot advance, load buffering/commit and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_index       <= C_LAST_IDX;
         r_shadow      <= '0;
         r_display     <= '0;
         r_pending     <= 1'b0;
         r_bcd_out     <= '0;
         r_digit_en    <= '0;
         r_blank       <= 1'b1;
         r_err         <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         if (w_tick) begin
            r_index       <= w_next_index;
            r_display     <= w_next_display;
            r_bcd_out     <= w_next_digit;
            r_digit_en    <= NUM_DIGITS'(1) << w_next_index;
            r_blank       <= w_next_blank;
            r_err         <= w_next_err;
            r_frame_start <= w_frame_edge;
         end
         if (bus.load) begin
            r_shadow  <= bus.digits_in;
            r_pending <= !w_frame_edge;
         end else if (w_frame_edge) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign bus.bcd_out     = r_bcd_out;
   assign bus.digit_en    = r_digit_en;
   assign bus.blank       = r_blank;
   assign bus.err         = r_err;
   assign bus.frame_start = r_frame_start;
   assign bus.pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl (4 digits, 4-cycle
//               slots) with a slot-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

   localparam int N   = 4;
   localparam int DIV = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   started = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

   seg_scan_ctrl #(
      .NUM_DIGITS  (N),
      .REFRESH_DIV (DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: edge count since reset release, digit arrays.
   int          e;
   int          disp   [N];
   int          shadow [N];
   int          din    [N];
   bit          pend;
   int          m_bcd, m_en;
   bit          m_blank, m_err, m_fs;
   logic [15:0] din_vec;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model: slot s = e/DIV starts at every DIV-th edge; slot s shows digit (s-1)%N.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e = 0; pend = 0;
         for (int j = 0; j < N; j++) begin disp[j] = 0; shadow[j] = 0; end
         m_bcd = 0; m_en = 0; m_blank = 1; m_err = 0; m_fs = 0;
      end else begin
         int  idx;
         bit  tick, boundary, allz;
         e++;
         tick     = (e % DIV) == 0;
         idx      = tick ? ((e / DIV) - 1) % N : 0;
         boundary = tick && (idx == 0);
         din_vec  = bus.digits_in;
         for (int j = 0; j < N; j++) din[j] = int'((din_vec >> (4*j)) & 16'hF);
         if (boundary) begin
            if (bus.load) begin
               for (int j = 0; j < N; j++) begin disp[j] = din[j]; shadow[j] = din[j]; end
               pend = 0;
            end else if (pend) begin
               for (int j = 0; j < N; j++) disp[j] = shadow[j];
               pend = 0;
            end
         end else if (bus.load) begin
            for (int j = 0; j < N; j++) shadow[j] = din[j];
            pend = 1;
         end
         m_fs = 0;
         if (tick) begin
            m_bcd = disp[idx];
            m_en  = 1 << idx;
            m_err = (m_bcd > 9);
            allz  = 1;
            for (int j = idx; j < N; j++) if (disp[j] != 0) allz = 0;
            m_blank = m_err || (bus.blank_lz && idx != 0 && allz);
            m_fs    = boundary;
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (started) begin
         chk("cyc_bcd_out",     int'(bus.bcd_out),     m_bcd);
         chk("cyc_digit_en",    int'(bus.digit_en),    m_en);
         chk("cyc_blank",       int'(bus.blank),       int'(m_blank));
         chk("cyc_err",         int'(bus.err),         int'(m_err));
         chk("cyc_frame_start", int'(bus.frame_start), int'(m_fs));
         chk("cyc_pending",     int'(bus.pending),     int'(pend));
      end
   end

   task automatic wait_edge(input int target);
      int guard = 0;
      while (e < target) begin
         @(posedge clk);
         #1;
         guard++;
         if (guard > 500) begin
            n_fail++;
            $display("FAIL wait_edge: edge %0d not reached (at %0d)", target, e);
            $fatal(1, "timeout");
         end
      end
   endtask

   task automatic load_at(input int edge_n, input logic [15:0] val);
      wait_edge(edge_n - 1);
      bus.load      = 1'b1;
      bus.digits_in = val;
      wait_edge(edge_n);
      bus.load      = 1'b0;
   endtask

   initial begin
      bus.load = 1'b0; bus.digits_in = '0; bus.blank_lz = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      started = 1'b1;

      // Reset state and first frame with a load before the boundary
      wait_edge(1);
      chk("rst_digit_en", int'(bus.digit_en), 0);
      chk("rst_blank",    int'(bus.blank),    1);
      chk("rst_bcd_out",  int'(bus.bcd_out),  0);
      load_at(2, 16'h1234);
      wait_edge(3);  chk("ld_pending", int'(bus.pending), 1);
      wait_edge(4);
      chk("e4_digit_en", int'(bus.digit_en), 1);
      chk("e4_bcd_out",  int'(bus.bcd_out),  4);
      chk("e4_fs",       int'(bus.frame_start), 1);
      chk("e4_pending",  int'(bus.pending),  0);
      chk("e4_blank",    int'(bus.blank),    0);
      wait_edge(5);  chk("e5_fs", int'(bus.frame_start), 0);
      wait_edge(8);
      chk("e8_digit_en", int'(bus.digit_en), 2);
      chk("e8_bcd_out",  int'(bus.bcd_out),  3);

      // Mid-frame load waits for the next boundary
      load_at(9, 16'h5678);
      wait_edge(10); chk("mid_pending", int'(bus.pending), 1);
      wait_edge(12); chk("e12_bcd_out", int'(bus.bcd_out), 2);
      wait_edge(16);
      chk("e16_bcd_out",  int'(bus.bcd_out),  1);
      chk("e16_digit_en", int'(bus.digit_en), 8);
      wait_edge(19); chk("e19_pending", int'(bus.pending), 1);
      wait_edge(20);
      chk("e20_bcd_out", int'(bus.bcd_out), 8);
      chk("e20_pending", int'(bus.pending), 0);
      wait_edge(24); chk("e24_bcd_out", int'(bus.bcd_out), 7);
      wait_edge(28); chk("e28_bcd_out", int'(bus.bcd_out), 6);
      wait_edge(32); chk("e32_bcd_out", int'(bus.bcd_out), 5);

      // Load on the boundary tick bypasses the shadow
      load_at(36, 16'h9999);
      chk("byp_bcd_out", int'(bus.bcd_out), 9);
      chk("byp_pending", int'(bus.pending), 0);

      // Leading-zero blanking on and off
      load_at(40, 16'h0007);
      wait_edge(52);
      chk("lz_s0_bcd",   int'(bus.bcd_out), 7);
      chk("lz_s0_blank", int'(bus.blank),   0);
      wait_edge(56);
      chk("lz_s1_blank", int'(bus.blank),   1);
      chk("lz_s1_bcd",   int'(bus.bcd_out), 0);
      wait_edge(60); chk("lz_s2_blank", int'(bus.blank), 1);
      wait_edge(64); chk("lz_s3_blank", int'(bus.blank), 1);
      bus.blank_lz = 1'b0;
      wait_edge(68);
      chk("nolz_s0_bcd",   int'(bus.bcd_out), 7);
      chk("nolz_s0_blank", int'(bus.blank),   0);
      load_at(70, 16'h00A3);
      wait_edge(72);
      chk("nolz_s1_blank", int'(bus.blank),   0);
      chk("nolz_s1_bcd",   int'(bus.bcd_out), 0);

      // Invalid digit flags err and blank
      wait_edge(84);
      chk("bad_s0_bcd", int'(bus.bcd_out), 3);
      chk("bad_s0_err", int'(bus.err),     0);
      wait_edge(88);
      chk("bad_s1_bcd",   int'(bus.bcd_out), 10);
      chk("bad_s1_err",   int'(bus.err),     1);
      chk("bad_s1_blank", int'(bus.blank),   1);

      // Asynchronous reset mid-frame discards pending data
      load_at(89, 16'h1111);
      chk("pre_rst_pending", int'(bus.pending), 1);
      #3 rst = 1'b1;
      #1;
      chk("arst_digit_en", int'(bus.digit_en), 0);
      chk("arst_blank",    int'(bus.blank),    1);
      chk("arst_bcd_out",  int'(bus.bcd_out),  0);
      chk("arst_pending",  int'(bus.pending),  0);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_edge(4);
      chk("post_rst_bcd",     int'(bus.bcd_out),  0);
      chk("post_rst_en",      int'(bus.digit_en), 1);
      chk("post_rst_pending", int'(bus.pending),  0);
      chk("post_rst_fs",      int'(bus.frame_start), 1);
      wait_edge(8);
      chk("post_rst_en8", int'(bus.digit_en), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
